rice_bus_sram_slave: RTL and testbench

- Single-port on-chip data SRAM that acts as the responder side of rice_bus_if. It serves the data-bus requests issued by the core LSU.
- Accepts one request per cycle. Writes are byte-strobed and return no response. Reads return data in order through a 2-entry response queue, so the master may apply back-pressure.
- Sits directly on the core data bus in standalone core configurations and in simulation tops.

---
 rtl/rice_bus_pkg.sv | 10 +
 rtl/rice_bus_if.sv | 22 ++
 rtl/rice_bus_response_fifo.sv | 34 +++
 rtl/rice_bus_sram_slave.sv | 63 ++++++
 tb/tb_rice_bus_sram_slave.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rice_bus_pkg.sv
// rice_bus_pkg: shared bus width and byte/offset helpers for rice_bus responders
package rice_bus_pkg;
  localparam int RICE_BUS_XLEN = 32;
  function automatic int byte_size(input int xlen);
    return xlen / 8;
  endfunction
  function automatic int offset_width(input int xlen);
    return $clog2(xlen / 8);
  endfunction
endpackage

// File: rtl/rice_bus_if.sv
// rice_bus_if: LSU data bus with a valid/ready request channel and a valid/ready read response channel
interface rice_bus_if #(
  parameter int XLEN = rice_bus_pkg::RICE_BUS_XLEN
);
  logic                                    request_valid;
  logic                                    request_ready;
  logic                                    request_write;
  logic [XLEN-1:0]                         address;
  logic [rice_bus_pkg::byte_size(XLEN)-1:0] strobe;
  logic [XLEN-1:0]                         write_data;
  logic                                    response_valid;
  logic                                    response_ready;
  logic [XLEN-1:0]                         read_data;
  modport master (
    output request_valid, request_write, address, strobe, write_data, response_ready,
    input  request_ready, response_valid, read_data
  );
  modport slave (
    input  request_valid, request_write, address, strobe, write_data, response_ready,
    output request_ready, response_valid, read_data
  );
endinterface

// File: rtl/rice_bus_response_fifo.sv
// rice_bus_response_fifo: 2-entry in-order response queue; head is always in slot0 so pop_data is a flop
module rice_bus_response_fifo #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] slot0, slot1;
  logic [1:0]       count;
  logic             do_push, do_pop;
  assign full     = count == 2'd2;
  assign empty    = count == 2'd0;
  assign pop_data = slot0;
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  // Occupancy and slot shifting; slot0 only changes on a pop or a push into an empty queue
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= 2'd0;
    end else begin
      count <= count + 2'(do_push) - 2'(do_pop);
      if (do_pop && count == 2'd2) slot0 <= slot1;
      else if (do_push && (count == 2'd0 || (count == 2'd1 && do_pop))) slot0 <= push_data;
      if (do_push && ((count == 2'd1 && !do_pop) || count == 2'd2)) slot1 <= push_data;
    end
endmodule

// File: rtl/rice_bus_sram_slave.sv
// rice_bus_sram_slave: single-port data SRAM serving rice_bus_if; writes are byte-strobed, reads return in order
// Define RICE_BUS_SRAM_ZERO_INIT_EN to sweep the array to zero after every reset before accepting requests.
module rice_bus_sram_slave
  import rice_bus_pkg::*;
#(
  parameter int XLEN  = RICE_BUS_XLEN,
  parameter int DEPTH = 1024
) (
  input logic       i_clk,
  input logic       i_rst,
  rice_bus_if.slave bus_if
);
  localparam int BYTE_SIZE    = byte_size(XLEN);
  localparam int OFFSET_WIDTH = offset_width(XLEN);
  localparam int INDEX_WIDTH  = $clog2(DEPTH);
  logic [XLEN-1:0]        mem [DEPTH];
  logic [INDEX_WIDTH-1:0] index, init_idx;
  logic                   ready_q, init_busy, fifo_full, fifo_empty;
  logic                   req_fire, wr_fire, rd_fire, resp_fire;
  logic                   unused_addr;
  assign index       = bus_if.address[OFFSET_WIDTH+:INDEX_WIDTH];
  assign unused_addr = ^{bus_if.address[OFFSET_WIDTH-1:0], bus_if.address[XLEN-1:OFFSET_WIDTH+INDEX_WIDTH]};
  assign bus_if.request_ready  = ready_q && !fifo_full && !init_busy;
  assign bus_if.response_valid = !fifo_empty;
  assign req_fire  = bus_if.request_valid && bus_if.request_ready;
  assign wr_fire   = req_fire && bus_if.request_write;
  assign rd_fire   = req_fire && !bus_if.request_write;
  assign resp_fire = bus_if.response_valid && bus_if.response_ready;
  // Keeps request_ready low while reset is asserted and rises on the first edge after release
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) ready_q <= 1'b0;
    else ready_q <= 1'b1;
`ifdef RICE_BUS_SRAM_ZERO_INIT_EN
  // Zero sweep: one word per cycle for DEPTH cycles, restarted by any reset
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      init_idx  <= '0;
      init_busy <= 1'b1;
    end else if (init_busy) begin
      init_idx  <= init_idx + 1'b1;
      init_busy <= init_idx != INDEX_WIDTH'(DEPTH - 1);
    end
`else
  assign init_idx  = '0;
  assign init_busy = 1'b0;
`endif
  // Array write port: zero sweep while initialising, otherwise strobed byte merge
  always_ff @(posedge i_clk)
    if (init_busy) mem[init_idx] <= '0;
    else if (wr_fire)
      for (int b = 0; b < BYTE_SIZE; b++)
        if (bus_if.strobe[b]) mem[index][8*b+:8] <= bus_if.write_data[8*b+:8];
  rice_bus_response_fifo #(.WIDTH(XLEN)) u_response_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .push      (rd_fire),
    .pop       (resp_fire),
    .push_data (mem[index]),
    .pop_data  (bus_if.read_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );
endmodule

// File: tb/tb_rice_bus_sram_slave.sv
// tb_rice_bus_sram_slave: randomized and directed checks of the SRAM responder against a word-array model
module tb_rice_bus_sram_slave;
  localparam int XLEN  = 32;
  localparam int DEPTH = 1024;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [31:0] mref [DEPTH];
  logic [31:0] exp_q [$];
  logic [31:0] got_q [$];
  rice_bus_if #(.XLEN(XLEN)) bus ();
  rice_bus_sram_slave #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (.i_clk(clk), .i_rst(rst), .bus_if(bus));
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog got no finish, required finish before time limit");
    $fatal(1);
  end
  // advance one clock, updating the model with whatever handshakes complete on this edge
  task automatic cycle();
    int w;
    if (bus.request_valid && bus.request_ready) begin
      w = int'((bus.address >> 2) % 32'(DEPTH));
      if (bus.request_write) begin
        for (int b = 0; b < 4; b++)
          if (bus.strobe[b]) mref[w][8*b+:8] = bus.write_data[8*b+:8];
      end else exp_q.push_back(mref[w]);
    end
    if (bus.response_valid && bus.response_ready) got_q.push_back(bus.read_data);
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    bit done;
    done = 1'b0;
    bus.request_valid = 1'b1;
    bus.request_write = wr;
    bus.address       = addr;
    bus.write_data    = data;
    bus.strobe        = strb;
    for (int n = 0; n < 50 && !done; n++) begin
      done = bus.request_ready;
      cycle();
    end
    bus.request_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL issue_accept addr=%h got no accept, required accept within 50 cycles", addr);
    end
  endtask
  task automatic test_reset();
    int n, want;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks += 3;
    if (bus.request_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b expected 0", bus.request_ready); end
    if (bus.response_valid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b expected 0", bus.response_valid); end
    if (bus.read_data !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h expected 0", bus.read_data); end
    rst = 1'b0;
    n = 0;
    while (bus.request_ready !== 1'b1 && n < 3 * DEPTH) begin
      cycle();
      n++;
    end
`ifdef RICE_BUS_SRAM_ZERO_INIT_EN
    want = DEPTH;
    for (int i = 0; i < DEPTH; i++) mref[i] = 32'h0;
`else
    want = 1;
`endif
    checks++;
    if (n != want) begin errors++; $display("FAIL reset_ready_delay got %0d cycles expected %0d", n, want); end
  endtask
  task automatic test_word_rw();
    bus.response_ready = 1'b1;
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    issue(1'b0, 32'h10, 32'h0, 4'h0);
    checks += 2;
    if (bus.response_valid !== 1'b1) begin errors++; $display("FAIL word_rvalid got %b expected 1", bus.response_valid); end
    if (bus.read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL word_rdata got %h expected deadbeef", bus.read_data); end
    cycle();
    checks += 2;
    if (bus.response_valid !== 1'b0) begin errors++; $display("FAIL word_drain got %b expected 0", bus.response_valid); end
    if (got_q.size() != 1 || got_q[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL word_resp got %0d responses expected 1 of deadbeef", got_q.size()); end
    exp_q.delete();
    got_q.delete();
  endtask
  task automatic test_strobe_merge();
    bus.response_ready = 1'b1;
    issue(1'b1, 32'h20, 32'h11223344, 4'hF);
    issue(1'b1, 32'h20, 32'h000000AA, 4'h1);
    issue(1'b1, 32'h20, 32'hBB000000, 4'h8);
    issue(1'b0, 32'h20, 32'h0, 4'h0);
    checks++;
    if (bus.read_data !== 32'hBB2233AA) begin errors++; $display("FAIL strobe_merge got %h expected bb2233aa", bus.read_data); end
    cycle();
    issue(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0);
    issue(1'b0, 32'h20, 32'h0, 4'h0);
    checks++;
    if (bus.read_data !== 32'hBB2233AA) begin errors++; $display("FAIL strobe_zero got %h expected bb2233aa", bus.read_data); end
    cycle();
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL strobe_count got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL strobe_resp%0d got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    exp_q.delete();
    got_q.delete();
  endtask
  task automatic test_back_pressure();
    bus.response_ready = 1'b0;
    bus.request_valid  = 1'b1;
    bus.request_write  = 1'b0;
    bus.address        = 32'h10;
    cycle();
    bus.address = 32'h20;
    cycle();
    checks += 3;
    if (bus.request_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b expected 0", bus.request_ready); end
    if (bus.response_valid !== 1'b1) begin errors++; $display("FAIL bp_rvalid got %b expected 1", bus.response_valid); end
    if (bus.read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL bp_head got %h expected deadbeef", bus.read_data); end
    bus.address = 32'h10;
    cycle();
    cycle();
    checks += 2;
    if (bus.request_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_ready got %b expected 0", bus.request_ready); end
    if (bus.read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL bp_hold got %h expected deadbeef", bus.read_data); end
    bus.response_ready = 1'b1;
    cycle();
    checks += 2;
    if (bus.request_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop got %b expected 1", bus.request_ready); end
    if (bus.read_data !== 32'hBB2233AA) begin errors++; $display("FAIL bp_second got %h expected bb2233aa", bus.read_data); end
    cycle();
    bus.request_valid = 1'b0;
    checks += 2;
    if (bus.response_valid !== 1'b1) begin errors++; $display("FAIL bp_third_valid got %b expected 1", bus.response_valid); end
    if (bus.read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL bp_third got %h expected deadbeef", bus.read_data); end
    cycle();
    checks += 2;
    if (bus.response_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got %b expected 0", bus.response_valid); end
    if (got_q.size() != 3) begin errors++; $display("FAIL bp_count got %0d expected 3", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_resp%0d got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    exp_q.delete();
    got_q.delete();
  endtask
  task automatic test_throughput();
    int low;
    bus.response_ready = 1'b1;
    for (int i = 0; i < 8; i++) issue(1'b1, 32'h100 + 32'(4 * i), $urandom, 4'hF);
    bus.request_valid = 1'b1;
    bus.request_write = 1'b0;
    low = 0;
    for (int i = 0; i < 8; i++) begin
      bus.address = 32'h100 + 32'(4 * i);
      if (bus.request_ready !== 1'b1) low++;
      cycle();
      checks++;
      if (bus.response_valid !== 1'b1) begin errors++; $display("FAIL tput_valid%0d got %b expected 1", i, bus.response_valid); end
    end
    bus.request_valid = 1'b0;
    cycle();
    checks += 3;
    if (low != 0) begin errors++; $display("FAIL tput_ready got %0d low cycles expected 0", low); end
    if (bus.response_valid !== 1'b0) begin errors++; $display("FAIL tput_drain got %b expected 0", bus.response_valid); end
    if (got_q.size() != 8) begin errors++; $display("FAIL tput_count got %0d expected 8", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL tput_resp%0d got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    exp_q.delete();
    got_q.delete();
  endtask
  task automatic test_alias();
    bus.response_ready = 1'b1;
    issue(1'b1, 32'h0000_0004, 32'h55, 4'hF);
    issue(1'b0, 32'h0000_1006, 32'h0, 4'h0);
    checks++;
    if (bus.read_data !== 32'h55) begin errors++; $display("FAIL alias got %h expected 00000055", bus.read_data); end
    cycle();
    exp_q.delete();
    got_q.delete();
  endtask
  task automatic test_random();
    logic hold;
    logic [31:0] held;
    bus.response_ready = 1'b1;
    for (int i = 0; i < 16; i++) issue(1'b1, 32'(4 * i), $urandom, 4'hF);
    for (int n = 0; n < 300; n++) begin
      bus.response_ready = $urandom_range(0, 3) != 0;
      bus.request_valid  = 1'($urandom_range(0, 1));
      bus.request_write  = 1'($urandom_range(0, 1));
      bus.address        = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      bus.write_data     = $urandom;
      bus.strobe         = 4'($urandom);
      hold = bus.response_valid && !bus.response_ready;
      held = bus.read_data;
      cycle();
      if (hold) begin
        checks++;
        if (bus.read_data !== held) begin errors++; $display("FAIL rand_hold cycle %0d got %h expected %h", n, bus.read_data, held); end
      end
    end
    bus.request_valid  = 1'b0;
    bus.response_ready = 1'b1;
    repeat (3) cycle();
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_resp%0d got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    exp_q.delete();
    got_q.delete();
  endtask
  task automatic test_reset_mid();
    int n;
    logic [31:0] want, addr;
    bus.response_ready = 1'b0;
    issue(1'b0, 32'h10, 32'h0, 4'h0);
    issue(1'b0, 32'h20, 32'h0, 4'h0);
    checks++;
    if (bus.response_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %b expected 1", bus.response_valid); end
    rst = 1'b1;
    #1;
    checks += 3;
    if (bus.response_valid !== 1'b0) begin errors++; $display("FAIL mid_rvalid got %b expected 0", bus.response_valid); end
    if (bus.request_ready !== 1'b0) begin errors++; $display("FAIL mid_ready got %b expected 0", bus.request_ready); end
    if (bus.read_data !== 32'h0) begin errors++; $display("FAIL mid_rdata got %h expected 0", bus.read_data); end
    exp_q.delete();
    got_q.delete();
    cycle();
    cycle();
    rst = 1'b0;
    bus.response_ready = 1'b1;
    n = 0;
    while (bus.request_ready !== 1'b1 && n < 3 * DEPTH) begin
      cycle();
      n++;
    end
`ifdef RICE_BUS_SRAM_ZERO_INIT_EN
    checks++;
    if (n != DEPTH) begin errors++; $display("FAIL mid_init_len got %0d cycles expected %0d", n, DEPTH); end
    for (int i = 0; i < DEPTH; i++) mref[i] = 32'h0;
    addr = $urandom;
    want = 32'h0;
`else
    checks++;
    if (n != 1) begin errors++; $display("FAIL mid_ready_delay got %0d cycles expected 1", n); end
    addr = 32'h10;
    want = mref[4];
`endif
    checks++;
    if (bus.response_valid !== 1'b0) begin errors++; $display("FAIL mid_stale got %b expected 0", bus.response_valid); end
    issue(1'b0, addr, 32'h0, 4'h0);
    checks++;
    if (bus.read_data !== want) begin errors++; $display("FAIL mid_read got %h expected %h", bus.read_data, want); end
    cycle();
    checks++;
    if (got_q.size() != 1) begin errors++; $display("FAIL mid_count got %0d expected 1", got_q.size()); end
  endtask
  initial begin
    bus.request_valid  = 1'b0;
    bus.request_write  = 1'b0;
    bus.address        = 32'h0;
    bus.strobe         = 4'h0;
    bus.write_data     = 32'h0;
    bus.response_ready = 1'b0;
    test_reset();
    test_word_rw();
    test_strobe_merge();
    test_back_pressure();
    test_throughput();
    test_alias();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
